// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 codes and access legality helpers for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} lsu_state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W);
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
        return (((f3 == F3_H) || (f3 == F3_HU)) && lane[0]) ||
               ((f3 == F3_W) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request, response and data-memory signals of the load/store unit
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DAT_WIDTH  = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DAT_WIDTH-1:0]  req_wdata;
    logic                  resp_valid;
    logic [DAT_WIDTH-1:0]  resp_rdata;
    logic                  resp_err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DAT_WIDTH-1:0]  mem_wdata;
    logic                  mem_we;
    logic                  mem_re;
    logic [DAT_WIDTH-1:0]  mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane extraction with sign/zero extension and sub-word store merge
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_val,
    output logic [31:0] merged
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = old_word[{lane, 3'b000} +: 8];
    assign half_sel = old_word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_val = old_word;
        merged   = old_word;
        case (funct3)
            F3_B: begin
                load_val = {{24{byte_sel[7]}}, byte_sel};
                merged[{lane, 3'b000} +: 8] = store_data[7:0];
            end
            F3_BU: load_val = {24'h0, byte_sel};
            F3_H: begin
                load_val = {{16{half_sel[15]}}, half_sel};
                merged[{lane[1], 4'b0000} +: 16] = store_data[15:0];
            end
            F3_HU: load_val = {16'h0, half_sel};
            default: merged = store_data;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store unit with read-modify-write for sub-word stores
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DAT_WIDTH  = 32,
    parameter int MEM_WORDS  = 64
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] MEM_WORDS_W = ADDR_WIDTH'(MEM_WORDS);

    lsu_state_t            state, state_nxt;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DAT_WIDTH-1:0]  wdata_q, old_q, rdata_q;
    logic                  err_q;
    logic                  accept, req_err, is_sw;
    logic [DAT_WIDTH-1:0]  align_old, load_val, merged;

    assign accept  = bus.req_valid && bus.req_ready;
    assign req_err = f3_illegal(bus.req_we, bus.req_funct3) ||
                     misaligned(bus.req_funct3, bus.req_addr[1:0]) ||
                     ((bus.req_addr >> 2) >= MEM_WORDS_W);
    assign is_sw   = we_q && (f3_q == F3_W);

    // MERGE has no live read, so the merge works on the word captured in ACCESS
    assign align_old = (state == MERGE) ? old_q : bus.mem_rdata;

    lsu_align u_align (
        .funct3     (f3_q),
        .lane       (addr_q[1:0]),
        .old_word   (align_old),
        .store_data (wdata_q),
        .load_val   (load_val),
        .merged     (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = req_err ? RESP : ACCESS;
            ACCESS:  state_nxt = (we_q && !is_sw) ? MERGE : RESP;
            MERGE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_re     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        case (state)
            IDLE:   bus.req_ready = !rst;
            ACCESS: begin
                bus.mem_addr = addr_q >> 2;
                if (is_sw) begin
                    bus.mem_we    = !rst;
                    bus.mem_wdata = wdata_q;
                end else begin
                    bus.mem_re = !rst;
                end
            end
            MERGE: begin
                bus.mem_addr  = addr_q >> 2;
                bus.mem_we    = !rst;
                bus.mem_wdata = merged;
            end
            RESP:    bus.resp_valid = !rst;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state == ACCESS) old_q <= bus.mem_rdata;
            // only an IDLE->RESP transition can be a rejected access
            if (state_nxt == RESP) begin
                rdata_q <= (state == ACCESS && !we_q) ? load_val : '0;
                err_q   <= (state == IDLE);
            end
        end
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit against a word-memory reference model
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int MEM_WORDS = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] mem     [0:MEM_WORDS-1];
    logic [31:0] ref_mem [0:MEM_WORDS-1];

    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_WIDTH(32), .DAT_WIDTH(32)) bus ();

    load_store_unit #(.ADDR_WIDTH(32), .DAT_WIDTH(32), .MEM_WORDS(MEM_WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mem_rdata = (bus.mem_addr < MEM_WORDS) ? mem[bus.mem_addr[5:0]] : 32'h0;

    always @(posedge clk)
        if (bus.mem_we === 1'b1 && bus.mem_addr < MEM_WORDS)
            mem[bus.mem_addr[5:0]] <= bus.mem_wdata;

    initial begin
        #400000;
        $fatal(1, "FAIL watchdog simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input bit we, input int f3, input logic [31:0] addr);
        int size;
        size = 1 << (f3 % 4);
        if (we && f3 > 2) return 1;
        if (!we && (f3 == 3 || f3 == 6 || f3 == 7)) return 1;
        if (addr % size != 0) return 1;
        if ((addr >> 2) >= MEM_WORDS) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] model_load(input int f3, input logic [31:0] addr);
        logic [63:0] v, mask;
        int n;
        n    = 1 << (f3 % 4);
        v    = {32'h0, ref_mem[addr >> 2]} >> (8 * (addr % 4));
        mask = (64'd1 << (8 * n)) - 64'd1;
        v    = v & mask;
        if (f3 < 4 && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_store(input int f3, input logic [31:0] addr, input logic [31:0] wd);
        logic [63:0] mask, res;
        int sh;
        sh   = 8 * (addr % 4);
        mask = ((64'd1 << (8 * (1 << f3))) - 64'd1) << sh;
        res  = ({32'h0, ref_mem[addr >> 2]} & ~mask) | (({32'h0, wd} << sh) & mask);
        return res[31:0];
    endfunction

    task automatic txn(input string tag, input bit we, input int f3,
                       input logic [31:0] addr, input logic [31:0] wd);
        bit          e, sub;
        int          exp_lat, lat, n_we, n_re, we_cyc, re_cyc;
        logic [31:0] exp_rdata, exp_word, w_addr, w_data;
        e         = model_err(we, f3, addr);
        sub       = we && (f3 != 2);
        exp_lat   = e ? 1 : (sub ? 3 : 2);
        exp_rdata = (e || we) ? 32'h0 : model_load(f3, addr);
        exp_word  = (!e && we) ? model_store(f3, addr, wd) : 32'h0;
        @(negedge clk);
        check({tag, "_ready"}, bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = 3'(f3);
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        bus.req_funct3 = 3'($urandom_range(0, 7));
        lat = 0; n_we = 0; n_re = 0; we_cyc = 0; re_cyc = 0;
        w_addr = 32'h0; w_data = 32'h0;
        for (int c = 1; c <= 6; c++) begin
            if (bus.mem_we === 1'b1) begin
                n_we++; we_cyc = c; w_addr = bus.mem_addr; w_data = bus.mem_wdata;
            end
            if (bus.mem_re === 1'b1) begin
                n_re++; re_cyc = c;
            end
            if (bus.resp_valid === 1'b1) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
        check({tag, "_err"}, bus.resp_err, e);
        check({tag, "_nwe"}, n_we, (!e && we) ? 1 : 0);
        check({tag, "_nre"}, n_re, (!e && (!we || sub)) ? 1 : 0);
        if (!e && (!we || sub)) check({tag, "_re_cyc"}, re_cyc, 1);
        if (!e && we) begin
            check({tag, "_we_cyc"}, we_cyc, sub ? 2 : 1);
            check({tag, "_waddr"}, w_addr, addr >> 2);
            check({tag, "_wdata"}, w_data, exp_word);
            ref_mem[addr >> 2] = exp_word;
        end
        if ((addr >> 2) < MEM_WORDS)
            check({tag, "_memword"}, mem[addr[7:2]], ref_mem[addr >> 2]);
    endtask

    initial begin
        logic [31:0] saved, a;
        int          f3, sent, got, since;
        bit          we, acc;
        logic [31:0] q[$];

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[3] = 32'h8000_80F0; ref_mem[3] = 32'h8000_80F0;
        mem[5] = 32'h1122_3344; ref_mem[5] = 32'h1122_3344;

        repeat (3) @(negedge clk);
        check("rst_ready", bus.req_ready, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_re", bus.mem_re, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", bus.req_ready, 1);
        check("post_rst_valid", bus.resp_valid, 0);
        check("post_rst_rdata", bus.resp_rdata, 0);
        check("post_rst_err", bus.resp_err, 0);

        txn("lb",  0, 0, 32'h0C, 32'h0);
        check("lb_const", bus.resp_rdata, 32'hFFFF_FFF0);
        txn("lbu", 0, 4, 32'h0C, 32'h0);
        check("lbu_const", bus.resp_rdata, 32'h0000_00F0);
        txn("lh",  0, 1, 32'h0E, 32'h0);
        check("lh_const", bus.resp_rdata, 32'hFFFF_8000);
        txn("sb",  1, 0, 32'h15, 32'hAB);
        check("sb_const", mem[5], 32'h1122_AB44);
        txn("sw",  1, 2, 32'h08, 32'hDEAD_BEEF);
        txn("lw",  0, 2, 32'h08, 32'h0);
        check("lw_const", bus.resp_rdata, 32'hDEAD_BEEF);

        txn("err_lw_mis",  0, 2, 32'h02, 32'h0);
        check("err_lw_mis_const", bus.resp_err, 1);
        txn("err_sh_mis",  1, 1, 32'h01, 32'h1234);
        txn("err_lw_oor",  0, 2, 32'h100, 32'h0);
        check("err_lw_oor_const", bus.resp_err, 1);
        txn("err_ld_f3",   0, 3, 32'h00, 32'h0);
        txn("err_st_f3",   1, 4, 32'h10, 32'h55);

        // reset asserted during MERGE of a byte store: the write must be dropped
        saved = ref_mem[1];
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_B;
        bus.req_addr = 32'h04; bus.req_wdata = 32'h5A;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rstm_access_re", bus.mem_re, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstm_merge_we", bus.mem_we, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstm_ready", bus.req_ready, 1);
        check("rstm_valid", bus.resp_valid, 0);
        check("rstm_word1", mem[1], saved);

        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) f3 = we ? $urandom_range(0, 2) : ((f3 % 2 == 0) ? (f3 % 3) : 4 + (f3 % 2));
            a = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) != 0) a = a & ~32'((1 << (f3 % 4)) - 1);
            txn("rnd", we, f3, a, $urandom);
        end

        // back-to-back loads with req_valid held high
        q.delete(); sent = 0; got = 0; since = 99;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = F3_W;
        bus.req_addr = 32'($urandom_range(0, 63)) << 2;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            if (since == 1 || since == 2) check("b2b_ready_low", bus.req_ready, 0);
            check("b2b_resp_slot", bus.resp_valid, (since == 2) ? 1 : 0);
            if (bus.resp_valid === 1'b1) begin
                if (q.size() == 0) check("b2b_extra_resp", 1, 0);
                else check("b2b_rdata", bus.resp_rdata, q.pop_front());
                got++;
            end
            acc = (bus.req_valid === 1'b1) && (bus.req_ready === 1'b1);
            if (acc) begin
                q.push_back(model_load(bus.req_funct3, bus.req_addr));
                sent++;
            end
            @(posedge clk);
            #1;
            since = acc ? 1 : since + 1;
            if (acc) begin
                if (sent < 4) begin
                    bus.req_funct3 = ($urandom_range(0, 1) != 0) ? F3_W : F3_BU;
                    bus.req_addr = (bus.req_funct3 == F3_W) ? (32'($urandom_range(0, 63)) << 2)
                                                            : 32'($urandom_range(0, 255));
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        check("b2b_sent", sent, 4);
        check("b2b_got", got, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
